seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Consumer end of the 8-channel display path: takes the selected 32-bit display word, the per-digit blink mask and the per-digit decimal-point mask.
- Drives the Nexys4 eight-digit common-anode 7-segment display by time-multiplexing the digits.
- Decodes each hex nibble into segments, applies blink and decimal point, and inserts a blanking guard between digits to suppress ghosting.
- Inputs are sampled once per scan frame, so one frame never mixes old and new data.

Parameters:
- SCAN_DIV, 100000: clk cycles per digit slot (1 ms at 100 MHz); must be >= 2.
- GUARD, 16: blank cycles at the start of each slot; must be < SCAN_DIV.
- BLINK_HALF, 64: frames per blink half-period (~512 ms at defaults); must be >= 1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- EN  in  1  display enable; 0 forces all anodes off, counters keep running
- Disp_num  in  32  eight hex nibbles; digit i = Disp_num[4i+3:4i], digit 0 rightmost
- LE  in  8  LE[i]=1: digit i blinks
- point  in  8  point[i]=1: decimal point of digit i lit
- AN  out  8  anodes, active-low, AN[i] selects digit i
- SEGMENT  out  8  {dp,g,f,e,d,c,b,a}, active-low
- frame_start  out  1  one-cycle pulse when a new frame is captured

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset values: cnt=0, idx=0, frame_cnt=0, blink_phase=0, shadow regs=0, AN=8'hFF, SEGMENT=8'hFF, frame_start=0. Reset mid-frame aborts the scan immediately; outputs are dark on the next edge.
- Slot counter: cnt counts 0..SCAN_DIV-1 and wraps. On wrap, idx increments 0..7 and wraps.
- Frame capture: on any cycle with idx==0 and cnt==0 and rst=0:
  - Disp_num, LE and point are registered into shadow regs.
  - frame_start is registered high (visible the next cycle, exactly one cycle).
  - The first capture occurs on the first cycle after reset release.
  - Input changes at any other time have no effect until the next capture.
- Frame counter: when idx wraps 7->0, frame_cnt increments. When frame_cnt==BLINK_HALF-1 it resets to 0 and blink_phase toggles.
- Output registers: AN and SEGMENT are registered and reflect the cnt/idx state of the previous cycle (1-cycle latency).
  - Digit i lit when rst=0, EN=1, cnt>=GUARD, and not (blink_phase=1 and LE_s[i]=1).
  - When lit: AN = ~(1<<idx), SEGMENT[6:0] = decode(nibble idx), SEGMENT[7] = ~point_s[idx].
  - Otherwise: AN=8'hFF and SEGMENT=8'hFF.
- Decode (hex -> SEGMENT[6:0], active-low): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
- Blink blanks the whole digit, including dp.
- EN=0 does not stall cnt, idx, frame_cnt or captures.
- At most one AN bit is ever low. An all-high AN and SEGMENT occurs during every guard interval.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined:
  - At capture, compute lz_mask from the shadowed Disp_num: digit i (i>=1) is blanked if nibbles 7..i are all zero.
  - Digit 0 is never blanked by this rule.
  - A blanked digit behaves as unlit (AN=8'hFF) even if its point bit is set.
- Undefined: all eight digits are always shown. No lz_mask logic is present.

Test Plan (SCAN_DIV=8, GUARD=2, BLINK_HALF=2):
- Reset release with Disp_num=32'h01234567, point=0, LE=0, EN=1:
  - frame_start high exactly 1 cycle, on the 2nd cycle after release.
  - Slot 0 has 2 cycles AN=FF, then AN=FE, SEGMENT=8'hF8 ("7") for 6 cycles.
  - Slot 7 shows AN=7F, SEGMENT=8'hC0.
- Change Disp_num to 32'hFFFFFFFF mid-frame (idx=3):
  - Digits 3..7 still show the old values.
  - From the next frame every digit shows SEGMENT=8'h8E.
- point=8'h01, Disp_num nibble0=8 -> digit 0 shows SEGMENT=8'h00; all others have bit7=1.
- LE=8'h04 across 5 frames:
  - Digit 2 lit in frames 0-1, dark (AN[2]=1) in frames 2-3, lit in frame 4.
  - Other digits are unaffected.
- Mid-slot effects:
  - EN=0 mid-slot -> AN=FF from the next cycle; cnt/idx continue.
  - rst pulsed mid-slot -> AN=FF, SEGMENT=FF next cycle; idx restarts at 0 and a fresh capture follows.
- With SEG7_LEADING_ZERO_BLANK_EN and Disp_num=32'h00000A05:
  - Digits 3..7 stay dark.
  - Digit 1 shows "0" (SEGMENT=8'hC0).
  - With Disp_num=0, only digit 0 is lit.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Eight-digit common-anode 7-segment scan driver with per-frame input capture, blink and guard blanking.
// Optional SEG7_LEADING_ZERO_BLANK_EN: blank leading zero digits (digit 0 always shown).
module seg7_scan_driver #(
    parameter int SCAN_DIV   = 100000,
    parameter int GUARD      = 16,
    parameter int BLINK_HALF = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        EN,
    input  logic [31:0] Disp_num,
    input  logic [7:0]  LE,
    input  logic [7:0]  point,
    output logic [7:0]  AN,
    output logic [7:0]  SEGMENT,
    output logic        frame_start
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int FW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] GUARD_CNT  = CW'(GUARD);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_HALF - 1);

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [FW-1:0] frame_cnt;
    logic          blink_phase;
    logic [31:0]   disp_s;
    logic [7:0]    le_s;
    logic [7:0]    point_s;

    logic          capture;
    logic [31:0]   disp_eff;
    logic [7:0]    le_eff;
    logic [7:0]    point_eff;
    logic [3:0]    nibble;
    logic          lit;
    logic [7:0]    an_d;
    logic [7:0]    seg_d;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        unique case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [7:0] lz_s;
    logic [7:0] lz_next;
    logic [7:0] lz_eff;
    logic       zero_run;

    always_comb begin
        zero_run = 1'b1;
        lz_next  = '0;
        for (int i = 7; i >= 1; i--) begin
            zero_run   = zero_run && (Disp_num[4*i +: 4] == 4'h0);
            lz_next[i] = zero_run;
        end
    end
`endif

    // On the capture cycle the shadow regs are still stale, so the output path
    // looks at the incoming values; keeps a frame coherent even with GUARD=0.
    always_comb begin
        capture   = (idx == 3'd0) && (cnt == '0);
        disp_eff  = capture ? Disp_num : disp_s;
        le_eff    = capture ? LE       : le_s;
        point_eff = capture ? point    : point_s;
        nibble    = disp_eff[{idx, 2'b00} +: 4];
        lit       = EN && (cnt >= GUARD_CNT) && !(blink_phase && le_eff[idx]);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        lz_eff    = capture ? lz_next : lz_s;
        lit       = lit && !lz_eff[idx];
`endif
        an_d  = 8'hFF;
        seg_d = 8'hFF;
        if (lit) begin
            an_d  = ~(8'd1 << idx);
            seg_d = {~point_eff[idx], hex_to_seg(nibble)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            idx         <= 3'd0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            disp_s      <= '0;
            le_s        <= '0;
            point_s     <= '0;
            AN          <= 8'hFF;
            SEGMENT     <= 8'hFF;
            frame_start <= 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            lz_s        <= '0;
`endif
        end else begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= idx + 3'd1;
                if (idx == 3'd7) begin
                    if (frame_cnt == FRAME_LAST) begin
                        frame_cnt   <= '0;
                        blink_phase <= ~blink_phase;
                    end else begin
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                end
            end else begin
                cnt <= cnt + 1'b1;
            end

            frame_start <= capture;
            if (capture) begin
                disp_s  <= Disp_num;
                le_s    <= LE;
                point_s <= point;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
                lz_s    <= lz_next;
`endif
            end

            AN      <= an_d;
            SEGMENT <= seg_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: a cycle-position reference model (time since reset -> slot, digit, frame).
// Leading-zero expectations follow SEG7_LEADING_ZERO_BLANK_EN when defined.
module tb_seg7_scan_driver;

    localparam int SCAN_DIV   = 8;
    localparam int GUARD      = 2;
    localparam int BLINK_HALF = 2;
    localparam int FRAME      = SCAN_DIV * 8;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam bit LZ_BUILD = 1'b1;
`else
    localparam bit LZ_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        EN = 1'b1;
    logic [31:0] Disp_num = '0;
    logic [7:0]  LE = '0;
    logic [7:0]  point = '0;
    logic [7:0]  AN;
    logic [7:0]  SEGMENT;
    logic        frame_start;

    seg7_scan_driver #(.SCAN_DIV(SCAN_DIV), .GUARD(GUARD), .BLINK_HALF(BLINK_HALF)) dut (
        .clk(clk), .rst(rst), .EN(EN), .Disp_num(Disp_num), .LE(LE), .point(point),
        .AN(AN), .SEGMENT(SEGMENT), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // Model state: p = clock edges since reset release.
    int          p = 0;
    int          m_cnt = 0;
    int          m_idx = 0;
    logic [31:0] m_disp = '0;
    logic [7:0]  m_le = '0;
    logic [7:0]  m_pt = '0;
    logic [7:0]  exp_an = 8'hFF;
    logic [7:0]  exp_seg = 8'hFF;
    logic        exp_fs = 1'b0;

    function automatic logic [6:0] seg_of(input logic [3:0] h);
        logic [6:0] tbl [16];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return tbl[h];
    endfunction

    task automatic tick();
        int c, d, f;
        bit lit, lz;
        @(posedge clk);
        if (rst) begin
            p = 0; m_cnt = 0; m_idx = 0;
            exp_an = 8'hFF; exp_seg = 8'hFF; exp_fs = 1'b0;
        end else begin
            c = p % SCAN_DIV;
            d = (p / SCAN_DIV) % 8;
            f = p / FRAME;
            exp_fs = (p % FRAME == 0);
            if (exp_fs) begin
                m_disp = Disp_num; m_le = LE; m_pt = point;
            end
            lz = LZ_BUILD && (d >= 1) && ((m_disp >> (4 * d)) == 0);
            lit = EN && (c >= GUARD) && !(((f / BLINK_HALF) % 2 == 1) && m_le[d]) && !lz;
            exp_an  = lit ? ~(8'd1 << d) : 8'hFF;
            exp_seg = lit ? {~m_pt[d], seg_of(m_disp[4*d +: 4])} : 8'hFF;
            m_cnt = c; m_idx = d;
            p++;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; Disp_num = 32'h01234567; point = 8'h00; LE = 8'h00; EN = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_chk++;
            if (AN !== 8'hFF || SEGMENT !== 8'hFF || frame_start !== 1'b0)
                $display("FAIL reset k=%0d got AN=%h SEG=%h fs=%b expected AN=ff SEG=ff fs=0", k, AN, SEGMENT, frame_start);
            else n_pass++;
        end
        rst = 1'b0;
    endtask

    task automatic test_first_frame();
        int fs_count = 0, first_fs = -1, dark0 = 0, lit0 = 0, lit7 = 0;
        for (int k = 0; k < FRAME; k++) begin
            tick();
            n_chk++;
            if (AN !== exp_an || SEGMENT !== exp_seg || frame_start !== exp_fs)
                $display("FAIL first_frame p=%0d got AN=%h SEG=%h fs=%b expected AN=%h SEG=%h fs=%b", p, AN, SEGMENT, frame_start, exp_an, exp_seg, exp_fs);
            else n_pass++;
            if (frame_start === 1'b1) begin
                fs_count++;
                if (first_fs < 0) first_fs = k;
            end
            if (k < GUARD && AN === 8'hFF) dark0++;
            if (AN === 8'hFE && SEGMENT === 8'hF8) lit0++;
            if (AN === 8'h7F && SEGMENT === 8'hC0) lit7++;
        end
        n_chk++;
        if (fs_count != 1 || first_fs != 0)
            $display("FAIL frame_start_pulse got count=%0d at=%0d expected count=1 at=0", fs_count, first_fs);
        else n_pass++;
        n_chk++;
        if (dark0 != GUARD) $display("FAIL slot0_guard got %0d expected %0d", dark0, GUARD); else n_pass++;
        n_chk++;
        if (lit0 != SCAN_DIV - GUARD) $display("FAIL slot0_digit7 got %0d expected %0d", lit0, SCAN_DIV - GUARD); else n_pass++;
        n_chk++;
        if (lit7 != (LZ_BUILD ? 0 : SCAN_DIV - GUARD))
            $display("FAIL slot7_zero got %0d expected %0d", lit7, LZ_BUILD ? 0 : SCAN_DIV - GUARD);
        else n_pass++;
    endtask

    task automatic test_midframe_change();
        int old_hits = 0, new_hits = 0, k = 0;
        while (m_idx != 3 && k < FRAME) begin
            tick(); k++;
            n_chk++;
            if (AN !== exp_an || SEGMENT !== exp_seg || frame_start !== exp_fs)
                $display("FAIL midframe_pre p=%0d got AN=%h SEG=%h fs=%b expected AN=%h SEG=%h fs=%b", p, AN, SEGMENT, frame_start, exp_an, exp_seg, exp_fs);
            else n_pass++;
        end
        Disp_num = 32'hFFFFFFFF;
        k = 0;
        while (p % FRAME != 0 && k < FRAME) begin
            tick(); k++;
            n_chk++;
            if (AN !== exp_an || SEGMENT !== exp_seg || frame_start !== exp_fs)
                $display("FAIL midframe_old p=%0d got AN=%h SEG=%h fs=%b expected AN=%h SEG=%h fs=%b", p, AN, SEGMENT, frame_start, exp_an, exp_seg, exp_fs);
            else n_pass++;
            if (SEGMENT === 8'h8E) old_hits++;
        end
        for (int j = 0; j < FRAME; j++) begin
            tick();
            n_chk++;
            if (AN !== exp_an || SEGMENT !== exp_seg || frame_start !== exp_fs)
                $display("FAIL midframe_new p=%0d got AN=%h SEG=%h fs=%b expected AN=%h SEG=%h fs=%b", p, AN, SEGMENT, frame_start, exp_an, exp_seg, exp_fs);
            else n_pass++;
            if (AN !== 8'hFF && SEGMENT === 8'h8E) new_hits++;
        end
        n_chk++;
        if (old_hits != 0) $display("FAIL midframe_leak got %0d expected 0", old_hits); else n_pass++;
        n_chk++;
        if (new_hits != 8 * (SCAN_DIV - GUARD)) $display("FAIL midframe_F got %0d expected %0d", new_hits, 8 * (SCAN_DIV - GUARD)); else n_pass++;
    endtask

    task automatic test_point();
        int d0_hits = 0, bad_dp = 0, k = 0;
        Disp_num = ($urandom & 32'hFFFF_FFF0) | 32'h1000_0008;
        point = 8'h01;
        while (p % FRAME != 0 && k < FRAME) begin
            tick(); k++;
            n_chk++;
            if (AN !== exp_an || SEGMENT !== exp_seg || frame_start !== exp_fs)
                $display("FAIL point_align p=%0d got AN=%h SEG=%h fs=%b expected AN=%h SEG=%h fs=%b", p, AN, SEGMENT, frame_start, exp_an, exp_seg, exp_fs);
            else n_pass++;
        end
        for (int j = 0; j < FRAME; j++) begin
            tick();
            n_chk++;
            if (AN !== exp_an || SEGMENT !== exp_seg || frame_start !== exp_fs)
                $display("FAIL point p=%0d got AN=%h SEG=%h fs=%b expected AN=%h SEG=%h fs=%b", p, AN, SEGMENT, frame_start, exp_an, exp_seg, exp_fs);
            else n_pass++;
            if (AN === 8'hFE && SEGMENT === 8'h00) d0_hits++;
            if (AN !== 8'hFF && AN !== 8'hFE && SEGMENT[7] !== 1'b1) bad_dp++;
        end
        n_chk++;
        if (d0_hits != SCAN_DIV - GUARD) $display("FAIL point_d0 got %0d expected %0d", d0_hits, SCAN_DIV - GUARD); else n_pass++;
        n_chk++;
        if (bad_dp != 0) $display("FAIL point_others got %0d expected 0", bad_dp); else n_pass++;
        point = 8'h00;
    endtask

    task automatic test_blink();
        int d2, others, want;
        rst = 1'b1;
        tick();
        n_chk++;
        if (AN !== 8'hFF || SEGMENT !== 8'hFF) $display("FAIL blink_reset got AN=%h SEG=%h expected AN=ff SEG=ff", AN, SEGMENT); else n_pass++;
        rst = 1'b0;
        LE = 8'h04;
        Disp_num = $urandom | 32'h1000_0000;
        point = 8'($urandom);
        for (int f = 0; f < 5; f++) begin
            d2 = 0; others = 0;
            for (int j = 0; j < FRAME; j++) begin
                tick();
                n_chk++;
                if (AN !== exp_an || SEGMENT !== exp_seg || frame_start !== exp_fs)
                    $display("FAIL blink p=%0d got AN=%h SEG=%h fs=%b expected AN=%h SEG=%h fs=%b", p, AN, SEGMENT, frame_start, exp_an, exp_seg, exp_fs);
                else n_pass++;
                if (AN === 8'hFB) d2++;
                else if (AN !== 8'hFF) others++;
            end
            want = (f == 2 || f == 3) ? 0 : SCAN_DIV - GUARD;
            n_chk++;
            if (d2 != want) $display("FAIL blink_digit2 frame=%0d got %0d expected %0d", f, d2, want); else n_pass++;
            n_chk++;
            if (others != 7 * (SCAN_DIV - GUARD)) $display("FAIL blink_others frame=%0d got %0d expected %0d", f, others, 7 * (SCAN_DIV - GUARD)); else n_pass++;
        end
        LE = 8'h00;
    endtask

    task automatic test_enable();
        int k = 0;
        while (m_cnt != 4 && k < 2 * SCAN_DIV) begin
            tick(); k++;
            n_chk++;
            if (AN !== exp_an || SEGMENT !== exp_seg || frame_start !== exp_fs)
                $display("FAIL enable_pre p=%0d got AN=%h SEG=%h fs=%b expected AN=%h SEG=%h fs=%b", p, AN, SEGMENT, frame_start, exp_an, exp_seg, exp_fs);
            else n_pass++;
        end
        EN = 1'b0;
        for (int j = 0; j < 10; j++) begin
            tick();
            n_chk++;
            if (AN !== 8'hFF || SEGMENT !== 8'hFF || frame_start !== exp_fs)
                $display("FAIL enable_off j=%0d got AN=%h SEG=%h fs=%b expected AN=ff SEG=ff fs=%b", j, AN, SEGMENT, frame_start, exp_fs);
            else n_pass++;
        end
        EN = 1'b1;
        for (int j = 0; j < FRAME; j++) begin
            tick();
            n_chk++;
            if (AN !== exp_an || SEGMENT !== exp_seg || frame_start !== exp_fs)
                $display("FAIL enable_resume p=%0d got AN=%h SEG=%h fs=%b expected AN=%h SEG=%h fs=%b", p, AN, SEGMENT, frame_start, exp_an, exp_seg, exp_fs);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        while (!(m_idx == 2 && m_cnt == 5) && k < 2 * FRAME) begin
            tick(); k++;
            n_chk++;
            if (AN !== exp_an || SEGMENT !== exp_seg || frame_start !== exp_fs)
                $display("FAIL rstmid_pre p=%0d got AN=%h SEG=%h fs=%b expected AN=%h SEG=%h fs=%b", p, AN, SEGMENT, frame_start, exp_an, exp_seg, exp_fs);
            else n_pass++;
        end
        rst = 1'b1;
        Disp_num = $urandom | 32'h1000_0000;
        point = 8'($urandom);
        tick();
        n_chk++;
        if (AN !== 8'hFF || SEGMENT !== 8'hFF || frame_start !== 1'b0)
            $display("FAIL rstmid_dark got AN=%h SEG=%h fs=%b expected AN=ff SEG=ff fs=0", AN, SEGMENT, frame_start);
        else n_pass++;
        rst = 1'b0;
        tick();
        n_chk++;
        if (frame_start !== 1'b1) $display("FAIL rstmid_capture got fs=%b expected fs=1", frame_start); else n_pass++;
        for (int j = 1; j < FRAME; j++) begin
            tick();
            n_chk++;
            if (AN !== exp_an || SEGMENT !== exp_seg || frame_start !== exp_fs)
                $display("FAIL rstmid_frame p=%0d got AN=%h SEG=%h fs=%b expected AN=%h SEG=%h fs=%b", p, AN, SEGMENT, frame_start, exp_an, exp_seg, exp_fs);
            else n_pass++;
        end
        point = 8'h00;
    endtask

    task automatic test_leading_zero();
        int lit_cnt [8];
        int d1_zero, want, k;
        logic [31:0] vals [2];
        vals[0] = 32'h00000A05;
        vals[1] = 32'h00000000;
        for (int v = 0; v < 2; v++) begin
            Disp_num = vals[v];
            point = (v == 0) ? 8'h00 : 8'hFF;
            LE = 8'h00; EN = 1'b1;
            k = 0;
            while (p % FRAME != 0 && k < FRAME) begin
                tick(); k++;
                n_chk++;
                if (AN !== exp_an || SEGMENT !== exp_seg || frame_start !== exp_fs)
                    $display("FAIL lz_align p=%0d got AN=%h SEG=%h fs=%b expected AN=%h SEG=%h fs=%b", p, AN, SEGMENT, frame_start, exp_an, exp_seg, exp_fs);
                else n_pass++;
            end
            for (int i = 0; i < 8; i++) lit_cnt[i] = 0;
            d1_zero = 0;
            for (int j = 0; j < FRAME; j++) begin
                tick();
                n_chk++;
                if (AN !== exp_an || SEGMENT !== exp_seg || frame_start !== exp_fs)
                    $display("FAIL lz p=%0d got AN=%h SEG=%h fs=%b expected AN=%h SEG=%h fs=%b", p, AN, SEGMENT, frame_start, exp_an, exp_seg, exp_fs);
                else n_pass++;
                for (int i = 0; i < 8; i++)
                    if (AN === ~(8'd1 << i)) lit_cnt[i]++;
                if (AN === 8'hFD && SEGMENT === 8'hC0) d1_zero++;
            end
            for (int i = 0; i < 8; i++) begin
                want = (LZ_BUILD && ((v == 0 && i >= 3) || (v == 1 && i >= 1))) ? 0 : SCAN_DIV - GUARD;
                n_chk++;
                if (lit_cnt[i] != want) $display("FAIL lz_digit case=%0d digit=%0d got %0d expected %0d", v, i, lit_cnt[i], want); else n_pass++;
            end
            if (v == 0) begin
                n_chk++;
                if (d1_zero != SCAN_DIV - GUARD) $display("FAIL lz_digit1_zero got %0d expected %0d", d1_zero, SCAN_DIV - GUARD); else n_pass++;
            end
        end
        point = 8'h00;
    endtask

    task automatic test_random();
        for (int j = 0; j < 6 * FRAME; j++) begin
            if ($urandom_range(9) == 0) Disp_num = $urandom;
            if ($urandom_range(9) == 0) LE = 8'($urandom);
            if ($urandom_range(9) == 0) point = 8'($urandom);
            if ($urandom_range(19) == 0) EN = ~EN;
            tick();
            n_chk++;
            if (AN !== exp_an || SEGMENT !== exp_seg || frame_start !== exp_fs)
                $display("FAIL random p=%0d got AN=%h SEG=%h fs=%b expected AN=%h SEG=%h fs=%b", p, AN, SEGMENT, frame_start, exp_an, exp_seg, exp_fs);
            else n_pass++;
            n_chk++;
            if ($countones(~AN) > 1) $display("FAIL random_onehot p=%0d got AN=%h expected at most one low bit", p, AN); else n_pass++;
        end
        EN = 1'b1;
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_midframe_change();
        test_point();
        test_blink();
        test_enable();
        test_reset_mid();
        test_leading_zero();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
